// File: rtl/key_expander.sv
// key_expander: iterative AES key schedule, one 32-bit word per cycle.
// Define KEY_EXP_ZEROIZE_EN to wipe all key material the cycle after done.
module key_expander #(
  parameter int NK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [32*NK-1:0]  key,
  output logic              busy,
  output logic [127:0]      rk,
  output logic [3:0]        rk_num,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic              done
);
  localparam int NR = NK + 6;
  localparam int TW = 4 * (NR + 1);

  if (NK != 4 && NK != 6 && NK != 8) begin : g_nk_chk
    $error("key_expander: NK must be 4, 6 or 8");
  end

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state;
  logic [31:0] win [NK];
  logic [31:0] grp [4];
  logic [5:0]  idx;
  logic [2:0]  pos;
  logic [7:0]  rcon;

  logic        first_pos, sub_pos, is_key, adv;
  logic [31:0] prev, sw_in, sw, temp, nw;

  // win[0] is w[i-NK], win[NK-1] is w[i-1]; key words rotate through
  always_comb begin
    prev      = win[NK-1];
    first_pos = (pos == 3'd0);
    sub_pos   = (NK == 8) && (pos == 3'd4);
    sw_in     = first_pos ? {prev[23:0], prev[31:24]} : prev;
    sw        = subword(sw_in);
    temp      = prev;
    if (first_pos) temp = sw ^ {rcon, 24'h0};
    else if (sub_pos) temp = sw;
    is_key    = (idx < 6'(NK));
    nw        = is_key ? win[0] : (win[0] ^ temp);
  end

  assign adv = (state == RUN) && !(rk_valid && !rk_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      rk       <= '0;
      rk_num   <= '0;
      idx      <= '0;
      pos      <= '0;
      rcon     <= 8'h01;
      for (int j = 0; j < NK; j++) win[j] <= '0;
      for (int j = 0; j < 4; j++) grp[j] <= '0;
    end else begin
      done <= 1'b0;
      if (rk_valid && rk_ready) rk_valid <= 1'b0;
`ifdef KEY_EXP_ZEROIZE_EN
      if (done) begin
        rk <= '0;
        for (int j = 0; j < NK; j++) win[j] <= '0;
        for (int j = 0; j < 4; j++) grp[j] <= '0;
      end
`endif
      unique case (state)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < NK; j++)
              win[j] <= key[32*(NK-1-j) +: 32];
            idx   <= '0;
            pos   <= '0;
            rcon  <= 8'h01;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (adv) begin
            for (int j = 0; j < NK - 1; j++) win[j] <= win[j+1];
            win[NK-1]      <= nw;
            grp[idx[1:0]]  <= nw;
            if (idx[1:0] == 2'd3) begin
              rk       <= {grp[0], grp[1], grp[2], nw};
              rk_num   <= idx[5:2];
              rk_valid <= 1'b1;
            end
            pos <= (pos == 3'(NK - 1)) ? 3'd0 : pos + 3'd1;
            if (!is_key && first_pos) rcon <= xt(rcon);
            idx <= idx + 6'd1;
            if (idx == 6'(TW - 1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rk_valid && rk_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_expander.sv
// tb_key_expander: directed FIPS-197 vectors for NK = 4, 6, 8.
// Covers stalls, ignored start, mid-run reset and back-to-back runs.
module tb_key_expander;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] K4  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ALT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K6  =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K8  =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  localparam logic [127:0] EXP4 [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         rst;
  logic [2:0]   start, rdy;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic [127:0] rk_a  [3];
  logic [3:0]   num_a [3];
  logic         v_a [3];
  logic         d_a [3];
  logic         b_a [3];

  int vectors = 0;
  int miscompares = 0;
  int sel = 0;
  int nhs = 0;
  int cyc = 0;
  logic [127:0] got  [16];
  logic [3:0]   gnum [16];

  logic [127:0] m_rk;
  logic [3:0]   m_num;
  logic         m_valid, m_done, m_busy;
  assign m_rk    = rk_a[sel];
  assign m_num   = num_a[sel];
  assign m_valid = v_a[sel];
  assign m_done  = d_a[sel];
  assign m_busy  = b_a[sel];

  key_expander #(.NK(4)) u4 (
    .clk(clk), .rst(rst), .start(start[0]), .key(key4),
    .busy(b_a[0]), .rk(rk_a[0]), .rk_num(num_a[0]),
    .rk_valid(v_a[0]), .rk_ready(rdy[0]), .done(d_a[0])
  );
  key_expander #(.NK(6)) u6 (
    .clk(clk), .rst(rst), .start(start[1]), .key(key6),
    .busy(b_a[1]), .rk(rk_a[1]), .rk_num(num_a[1]),
    .rk_valid(v_a[1]), .rk_ready(rdy[1]), .done(d_a[1])
  );
  key_expander #(.NK(8)) u8 (
    .clk(clk), .rst(rst), .start(start[2]), .key(key8),
    .busy(b_a[2]), .rk(rk_a[2]), .rk_num(num_a[2]),
    .rk_valid(v_a[2]), .rk_ready(rdy[2]), .done(d_a[2])
  );

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one expansion on instance s; records every handshaken round key
  task automatic run(input int s, input bit rnd, input bit poke);
    logic [127:0] prk;
    bit           pstall;
    prk    = '0;
    pstall = 1'b0;
    nhs    = 0;
    cyc    = 0;
    sel    = s;
    rdy[s] = 1'b1;
    start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    chk("busy_after_start", 128'(m_busy), 128'd1);
    while (cyc < 300) begin
      if (pstall) begin
        chk("stall_rk_hold", m_rk, prk);
        chk("stall_valid_hold", 128'(m_valid), 128'd1);
      end
      if (m_done) break;
      if (poke && cyc == 10) begin
        start[s] = 1'b1;
        key4 = ALT;
      end else begin
        start[s] = 1'b0;
      end
      if (rnd) rdy[s] = 1'($urandom_range(0, 1));
      if (m_valid && rdy[s] && nhs < 16) begin
        got[nhs]  = m_rk;
        gnum[nhs] = m_num;
        nhs++;
      end
      pstall = m_valid && !rdy[s];
      prk    = m_rk;
      @(posedge clk); #1;
      cyc++;
    end
    start[s] = 1'b0;
    rdy[s]   = 1'b1;
    chk("done_seen", 128'(m_done), 128'd1);
  endtask

  task automatic check4(input string tag);
    chk({tag, "_count"}, 128'(nhs), 128'd11);
    for (int k = 0; k < 11; k++) begin
      chk({tag, "_rk"}, got[k], EXP4[k]);
      chk({tag, "_num"}, 128'(gnum[k]), 128'(k));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    rdy   = '1;
    key4  = K4;
    key6  = K6;
    key8  = K8;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_busy", 128'(m_busy), 128'd0);
    chk("rst_valid", 128'(m_valid), 128'd0);
    chk("rst_done", 128'(m_done), 128'd0);
    chk("rst_rk", m_rk, 128'd0);
    chk("rst_num", 128'(m_num), 128'd0);

    run(0, 1'b0, 1'b0);
    chk("nk4_cycles", 128'(cyc), 128'd45);
    check4("nk4");
    @(posedge clk); #1;
    chk("done_pulse", 128'(m_done), 128'd0);
    chk("idle_busy", 128'(m_busy), 128'd0);
`ifdef KEY_EXP_ZEROIZE_EN
    chk("post_done_rk", m_rk, 128'd0);
`else
    chk("post_done_rk", m_rk, EXP4[10]);
`endif

    run(0, 1'b1, 1'b0);
    chk("stall_min_cycles", 128'(cyc >= 45), 128'd1);
    check4("stall");

    run(0, 1'b0, 1'b1);
    key4 = K4;
    chk("poke_cycles", 128'(cyc), 128'd45);
    check4("poke");

    sel      = 0;
    rdy[0]   = 1'b0;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre_rst_valid", 128'(m_valid), 128'd1);
    chk("pre_rst_rk", m_rk, EXP4[0]);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rdy[0] = 1'b1;
    chk("mid_rst_busy", 128'(m_busy), 128'd0);
    chk("mid_rst_valid", 128'(m_valid), 128'd0);
    chk("mid_rst_rk", m_rk, 128'd0);
    run(0, 1'b0, 1'b0);
    chk("after_rst_cycles", 128'(cyc), 128'd45);
    check4("after_rst");

    for (int p = 0; p < 2; p++) begin
      run(1, 1'b0, 1'b0);
      chk("nk6_cycles", 128'(cyc), 128'd53);
      chk("nk6_count", 128'(nhs), 128'd13);
      chk("nk6_rk0", got[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
      chk("nk6_rk12", got[12], 128'he98ba06f448c773c8ecc720401002202);
      chk("nk6_num12", 128'(gnum[12]), 128'd12);
    end

    run(2, 1'b0, 1'b0);
    chk("nk8_cycles", 128'(cyc), 128'd61);
    chk("nk8_count", 128'(nhs), 128'd15);
    chk("nk8_rk0", got[0], 128'h603deb1015ca71be2b73aef0857d7781);
    chk("nk8_rk1", got[1], 128'h1f352c073b6108d72d9810a30914dff4);
    chk("nk8_rk14", got[14], 128'hfe4890d1e6188d0b046df344706c631e);
    chk("nk8_num14", 128'(gnum[14]), 128'd14);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/key_expander.md
# key_expander

Iterative, parameterised AES key-schedule engine that expands a 128/192/256-bit cipher key into all NR+1 128-bit round keys. It produces one 32-bit schedule word per cycle and streams round keys out through a valid/ready handshake. It reuses the existing RotWord and SubWord word-level primitives. It feeds the round-key store in front of the cipher datapath, where the combinational all-rounds expander is too large.

## Interface

- NK, default 4: key length in 32-bit words; legal values 4, 6, 8 (AES-128/192/256). Any other value is a compile-time error.
- NR, derived as NK+6: number of rounds. Round keys emitted: NR+1. Total words: TW = 4*(NR+1), i.e. 44/52/60.
- clk  in  1  sole clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  expansion request. Sampled only in IDLE.
- key  in  32*NK  cipher key. Word 0 is the MSBs, FIPS-197 byte order. Sampled on the accepted start edge only.
- busy  out  1  high from the cycle after start acceptance until done.
- rk  out  128  current round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- rk_num  out  4  round index r of rk, 0..NR.
- rk_valid  out  1  rk/rk_num valid. Held until accepted.
- rk_ready  in  1  consumer accepts rk on rk_valid && rk_ready.
- done  out  1  one-cycle pulse on the handshake of round key NR.

## Operation

- States: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches key into an NK-word window, clears word index i=0, and goes to RUN.
- RUN produces w[i] each non-stalled cycle:
  - For i<NK: w[i] = key word i.
  - Otherwise let temp = w[i-1].
  - If i mod NK == 0: temp = SubWord(RotWord(temp)) ^ {rcon[i/NK], 24'h0}.
  - Else if NK==8 and i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp. The window shifts by one word.
- rcon sequence: 01,02,04,08,10,20,40,80,1b,36, indexed from 1. It is generated by an 8-bit xtime register, not a full table.
- Words accumulate into a 4-word assembly register. When the 4th word of group r is written, rk/rk_num=r load and rk_valid sets.
- Stall: while rk_valid && !rk_ready, word generation and i freeze; no word is lost or duplicated.
- After word TW-1 is written: state goes to DRAIN, waiting for the handshake of rk_num=NR. That handshake pulses done, clears busy and rk_valid, and returns to IDLE.
- start while busy is ignored; the key is not re-sampled.
- Reset, including mid-expansion, returns to IDLE. Reset values: busy=0, rk_valid=0, done=0, rk=0, rk_num=0, window/index cleared, rcon=01.

## Timing

- Start accepted at edge E0; busy=1 after E0.
- Word k is written at edge E(k+1), given rk_ready held high.
- rk_valid is high after edge E(4r+4) for round r. With rk_ready=1 it stays high exactly one cycle per round.
- Round NR is valid after E(TW). done and busy=0 follow its handshake edge, so 45 cycles start-to-done for NK=4, 53 for NK=6, 61 for NK=8.
- Each cycle rk_ready is low while rk_valid=1 adds exactly one cycle.
- Back-to-back: start is accepted in the first IDLE cycle after done.
- Combinational path per cycle: one SubWord plus XORs. No path from rk_ready to rk_valid.

## Configuration

- KEY_EXP_ZEROIZE_EN defined: one cycle after done, and on any reset, the key window, assembly register and rk are forced to 0. No key material persists after expansion.
- Undefined: the window and rk retain their last values after done; only reset clears them. Handshake timing is identical in both builds.

## Test plan

- NK=4, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk_num 1 = a0fafe1788542cb123a339392a6c7605; rk_num 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done 45 cycles after start.
- NK=6, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_num 0 = 8e73b0f7da0e6452c810f32b809079e5; rk_num 12 = e98ba06f448c773c8ecc720401002202; 13 handshakes.
- NK=8, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_num 14 = fe4890d1e6188d0b046df344706c631e; i mod 8 == 4 SubWord path exercised.
- NK=4, rk_ready randomly low 50% -> same 11 round keys in order, none dropped or duplicated, rk stable while stalled.
- start pulsed at cycle 10 of a run with a different key -> ignored, outputs unchanged. rst at cycle 20 -> busy=0, rk_valid=0, rk=0 next cycle; a new start then completes correctly.
- With KEY_EXP_ZEROIZE_EN -> rk=0 one cycle after done. Without it -> rk holds d014f9a8... after done.
